// File: rtl/alu_rr_arbiter_if.sv
// Issue/response bundle between two requesters, the response consumer and alu_rr_arbiter.
// The master side is the requester/consumer; the slave side is the arbiter.
interface alu_rr_arbiter_if #(parameter int N = 4);
    logic [1:0]   req;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic [1:0]   op0;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic [1:0]   op1;
    logic [1:0]   gnt;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_y;
    logic         rsp_cout;
    logic [3:0]   rsp_flags;
    logic         busy;

    modport master (
        output req, a0, b0, op0, a1, b1, op1, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_flags, busy
    );

    modport slave (
        input  req, a0, b0, op0, a1, b1, op1, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_flags, busy
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Two-requester front end sharing one Alu #(N), with a registered, id-tagged response.
// Define ALU_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module Alu #(parameter int N = 4) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [1:0]   i_c,
    output logic [N-1:0] o_y,
    output logic         o_cout,
    output logic [3:0]   o_flags
);
    logic [N:0] w_res;
    logic       w_ovf;

    // c: 00 add, 01 subtract (cout = no borrow), 10 and, 11 xor.
    // flags = {negative, zero, carry, signed overflow}.
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (i_c)
            2'b00: begin
                w_res = {1'b0, i_a} + {1'b0, i_b};
                w_ovf = (i_a[N-1] == i_b[N-1]) && (w_res[N-1] != i_a[N-1]);
            end
            2'b01: begin
                w_res = {1'b0, i_a} + {1'b0, ~i_b} + (N+1)'(1);
                w_ovf = (i_a[N-1] != i_b[N-1]) && (w_res[N-1] != i_a[N-1]);
            end
            2'b10: w_res = {1'b0, i_a & i_b};
            default: w_res = {1'b0, i_a ^ i_b};
        endcase
    end

    assign o_y     = w_res[N-1:0];
    assign o_cout  = w_res[N];
    assign o_flags = {w_res[N-1], ~|w_res[N-1:0], w_res[N], w_ovf};
endmodule

module alu_rr_arbiter #(parameter int N = 4) (
    input  logic              clk,
    input  logic              reset,
    alu_rr_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       r_state;
    state_t       w_nextState;
    logic         r_lastWinner;
    logic [N-1:0] r_opA;
    logic [N-1:0] r_opB;
    logic [1:0]   r_opC;
    logic         r_rspValid;
    logic         r_rspId;
    logic [N-1:0] r_rspY;
    logic         r_rspCout;
    logic [3:0]   r_rspFlags;
    logic         w_winner;
    logic [1:0]   w_gnt;
    logic [N-1:0] w_aluY;
    logic         w_aluCout;
    logic [3:0]   w_aluFlags;

    Alu #(.N(N)) uAlu (
        .i_a     (r_opA),
        .i_b     (r_opB),
        .i_c     (r_opC),
        .o_y     (w_aluY),
        .o_cout  (w_aluCout),
        .o_flags (w_aluFlags)
    );

    // Winner is only meaningful when req != 0; a lone request always wins.
    always_comb begin
`ifdef ALU_ARB_RR_EN
        if (bus.req == 2'b11)
            w_winner = ~r_lastWinner;
        else
            w_winner = bus.req[1] & ~bus.req[0];
`else
        w_winner = ~bus.req[0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    // r_lastWinner doubles as the in-flight requester id for gnt and rsp_id.
    always_comb begin
        w_nextState = r_state;
        w_gnt       = 2'b00;
        case (r_state)
            IDLE: begin
                if (bus.req != 2'b00)
                    w_nextState = EXEC;
            end
            EXEC: begin
                w_gnt       = r_lastWinner ? 2'b10 : 2'b01;
                w_nextState = RESP;
            end
            RESP: begin
                if (bus.rsp_ready)
                    w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lastWinner <= 1'b1;
            r_opA        <= '0;
            r_opB        <= '0;
            r_opC        <= '0;
            r_rspValid   <= 1'b0;
            r_rspId      <= 1'b0;
            r_rspY       <= '0;
            r_rspCout    <= 1'b0;
            r_rspFlags   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        r_lastWinner <= w_winner;
                        r_opA        <= w_winner ? bus.a1  : bus.a0;
                        r_opB        <= w_winner ? bus.b1  : bus.b0;
                        r_opC        <= w_winner ? bus.op1 : bus.op0;
                    end
                end
                EXEC: begin
                    r_rspY     <= w_aluY;
                    r_rspCout  <= w_aluCout;
                    r_rspFlags <= w_aluFlags;
                    r_rspId    <= r_lastWinner;
                    r_rspValid <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready)
                        r_rspValid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_id    = r_rspId;
    assign bus.rsp_y     = r_rspY;
    assign bus.rsp_cout  = r_rspCout;
    assign bus.rsp_flags = r_rspFlags;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: scoreboard of expected responses from an arithmetic
// reference model, checked with immediate assertions. Honours ALU_ARB_RR_EN for tie order.
module tb_alu_rr_arbiter;
    typedef struct {
        logic       id;
        logic [3:0] y;
        logic       cout;
        logic [3:0] flags;
    } rsp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    rsp_t sbQ[$];

    alu_rr_arbiter_if #(.N(4)) bus();

    alu_rr_arbiter #(.N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference built from integer arithmetic rather than bit-level adders.
    function automatic rsp_t aluModel(logic id, logic [3:0] a, logic [3:0] b, logic [1:0] op);
        rsp_t r;
        int ua, ub, sa, sb, res, sres;
        logic v;
        ua = a;
        ub = b;
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        v  = 1'b0;
        r.id   = id;
        r.cout = 1'b0;
        case (op)
            2'b00: begin
                res    = ua + ub;
                r.y    = res[3:0];
                r.cout = (res > 15);
                sres   = sa + sb;
                v      = (sres > 7) || (sres < -8);
            end
            2'b01: begin
                res    = ua - ub;
                r.y    = res[3:0];
                r.cout = (ua >= ub);
                sres   = sa - sb;
                v      = (sres > 7) || (sres < -8);
            end
            2'b10: r.y = a & b;
            default: r.y = a ^ b;
        endcase
        r.flags = {r.y[3], (r.y == 4'd0), r.cout, v};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(logic [1:0] req, logic [3:0] a0, logic [3:0] b0, logic [1:0] op0,
                                 logic [3:0] a1, logic [3:0] b1, logic [1:0] op1);
        bus.req = req;
        bus.a0  = a0;
        bus.b0  = b0;
        bus.op0 = op0;
        bus.a1  = a1;
        bus.b1  = b1;
        bus.op1 = op1;
    endtask

    task automatic pushExpected(logic id, logic [3:0] a, logic [3:0] b, logic [1:0] op);
        sbQ.push_back(aluModel(id, a, b, op));
    endtask

    task automatic checkResponse(string tag);
        rsp_t e;
        checkOutput({tag, "_valid"}, bus.rsp_valid, 1);
        if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s_sb: observed response, required none queued", tag);
        end else begin
            e = sbQ.pop_front();
            checkOutput({tag, "_id"},    bus.rsp_id,    e.id);
            checkOutput({tag, "_y"},     bus.rsp_y,     e.y);
            checkOutput({tag, "_cout"},  bus.rsp_cout,  e.cout);
            checkOutput({tag, "_flags"}, bus.rsp_flags, e.flags);
        end
    endtask

    // One request from requester 0 through grant, response and return to idle.
    task automatic runSingle(string tag, logic [3:0] a, logic [3:0] b, logic [1:0] op);
        applyStimulus(2'b01, a, b, op, 4'd0, 4'd0, 2'b00);
        pushExpected(1'b0, a, b, op);
        tick();
        checkOutput({tag, "_gnt"}, bus.gnt, 2'b01);
        checkOutput({tag, "_busy"}, bus.busy, 1);
        bus.req = 2'b00;
        tick();
        checkOutput({tag, "_gntOff"}, bus.gnt, 2'b00);
        checkResponse(tag);
        tick();
        checkOutput({tag, "_validOff"}, bus.rsp_valid, 0);
        checkOutput({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.rsp_ready = 1'b0;
        applyStimulus(2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 2'b00);
        tick();
        tick();
        reset = 1'b0;

        checkOutput("rst_gnt",   bus.gnt,       0);
        checkOutput("rst_valid", bus.rsp_valid, 0);
        checkOutput("rst_id",    bus.rsp_id,    0);
        checkOutput("rst_y",     bus.rsp_y,     0);
        checkOutput("rst_cout",  bus.rsp_cout,  0);
        checkOutput("rst_flags", bus.rsp_flags, 0);
        checkOutput("rst_busy",  bus.busy,      0);

        // Single request with the consumer always ready.
        bus.rsp_ready = 1'b1;
        runSingle("single", 4'b0011, 4'b0101, 2'b10);

        // Tie: fresh reset so last_winner favours requester 0 first.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(2'b11, 4'd1, 4'd2, 2'b00, 4'd7, 4'd1, 2'b01);
        pushExpected(1'b0, 4'd1, 4'd2, 2'b00);
`ifdef ALU_ARB_RR_EN
        pushExpected(1'b1, 4'd7, 4'd1, 2'b01);
`else
        pushExpected(1'b0, 4'd1, 4'd2, 2'b00);
`endif
        tick();
        checkOutput("tie1_gnt", bus.gnt, 2'b01);
        tick();
        checkResponse("tie1");
        tick();
        checkOutput("tie_idleGnt", bus.gnt, 2'b00);
        tick();
`ifdef ALU_ARB_RR_EN
        checkOutput("tie2_gnt", bus.gnt, 2'b10);
`else
        checkOutput("tie2_gnt", bus.gnt, 2'b01);
`endif
        bus.req = 2'b00;
        tick();
        checkResponse("tie2");
        tick();
        checkOutput("tie_idle", bus.busy, 0);

        // Backpressure with requester 1 waiting behind a held response.
        bus.rsp_ready = 1'b0;
        applyStimulus(2'b01, 4'd6, 4'd6, 2'b00, 4'd0, 4'd0, 2'b00);
        pushExpected(1'b0, 4'd6, 4'd6, 2'b00);
        pushExpected(1'b1, 4'd2, 4'd9, 2'b01);
        tick();
        checkOutput("bp_gnt0", bus.gnt, 2'b01);
        applyStimulus(2'b10, 4'd6, 4'd6, 2'b00, 4'd2, 4'd9, 2'b01);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_holdValid", bus.rsp_valid, 1);
            checkOutput("bp_holdGnt",   bus.gnt,       0);
            checkOutput("bp_holdY",     bus.rsp_y,     sbQ[0].y);
            checkOutput("bp_holdFlags", bus.rsp_flags, sbQ[0].flags);
        end
        checkResponse("bp0");
        bus.rsp_ready = 1'b1;
        tick();
        checkOutput("bp_release", bus.rsp_valid, 0);
        checkOutput("bp_gntWait", bus.gnt, 2'b00);
        tick();
        checkOutput("bp_gnt1", bus.gnt, 2'b10);
        bus.req = 2'b00;
        tick();
        checkResponse("bp1");
        tick();
        checkOutput("bp_idle", bus.busy, 0);

        // Reset during the grant cycle abandons the transaction.
        applyStimulus(2'b01, 4'd5, 4'd5, 2'b00, 4'd0, 4'd0, 2'b00);
        tick();
        checkOutput("rstx_gnt", bus.gnt, 2'b01);
        reset   = 1'b1;
        bus.req = 2'b00;
        tick();
        reset = 1'b0;
        checkOutput("rstx_gnt0",  bus.gnt,       0);
        checkOutput("rstx_valid", bus.rsp_valid, 0);
        checkOutput("rstx_y",     bus.rsp_y,     0);
        checkOutput("rstx_busy",  bus.busy,      0);
        tick();
        tick();
        checkOutput("rstx_noRsp", bus.rsp_valid, 0);

        // Every op code on two operand sets, covering carry and overflow.
        for (int s = 0; s < 2; s++) begin
            for (int op = 0; op < 4; op++) begin
                runSingle("ops", (s == 0) ? 4'b1111 : 4'b0111, 4'b0001, 2'(op));
            end
        end

        // Operands change right after the grant; response must use captured values.
        applyStimulus(2'b01, 4'b0100, 4'b0011, 2'b00, 4'd0, 4'd0, 2'b00);
        pushExpected(1'b0, 4'b0100, 4'b0011, 2'b00);
        tick();
        checkOutput("chg_gnt", bus.gnt, 2'b01);
        applyStimulus(2'b00, 4'b1110, 4'b1010, 2'b01, 4'd0, 4'd0, 2'b00);
        tick();
        bus.a0 = 4'b1111;
        checkResponse("chg");
        tick();
        checkOutput("chg_idle", bus.busy, 0);

        checkOutput("sb_drained", sbQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
